// File: rtl/jamma_input_scanner.sv
// JAMMA player/coin input scanner: alternates the P1/P2 mux select, samples both
// buses, debounces all 18 inputs per scan and stretches coin pulses.
module jamma_input_scanner #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_SCANS  = 4,
  parameter int COIN_HOLD_SCANS = 8
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic [7:0] I_JJOY,
  input  logic [5:0] I_JOYSTICK,
  input  logic [1:0] I_JCOIN,
  output logic       O_JSELECT,
  output logic [7:0] O_JOY1,
  output logic [7:0] O_JOY2,
  output logic [1:0] O_COIN,
  output logic       O_SCAN_DONE
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DEB_LIMIT   = CW'(DEBOUNCE_SCANS);
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    HOLD_LOAD   = 8'(COIN_HOLD_SCANS);

  typedef enum logic [2:0] {
    SEL1_SETTLE = 3'd0,
    SAMPLE1     = 3'd1,
    SEL2_SETTLE = 3'd2,
    SAMPLE2     = 3'd3,
    UPDATE      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    settle_q, settle_d;
  logic          jselect_q, jselect_d;
  logic [7:0]    raw1_q, raw1_d;
  logic [7:0]    raw2_q, raw2_d;
  logic [1:0]    rawc_q, rawc_d;
  logic [17:0]   deb_q, deb_d;
  logic [CW-1:0] cnt_q [18];
  logic [CW-1:0] cnt_d [18];
  logic [7:0]    hold_q [2];
  logic [7:0]    hold_d [2];
  logic [1:0]    coin_q, coin_d;
  logic [17:0]   raw_all;

  // Bit layout shared by raw and debounced vectors: [7:0]=P1, [15:8]=P2, [17:16]=coins.
  assign raw_all = {rawc_q, raw2_q, raw1_q};

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    raw1_d   = raw1_q;
    raw2_d   = raw2_q;
    rawc_d   = rawc_q;
    deb_d    = deb_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    coin_d   = coin_q;

    case (state_q)
      SEL1_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = SAMPLE1;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      SAMPLE1: begin
        raw1_d   = I_JJOY & {2'b11, I_JOYSTICK};
        rawc_d   = I_JCOIN;
        settle_d = '0;
        state_d  = SEL2_SETTLE;
      end
      SEL2_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = SAMPLE2;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      SAMPLE2: begin
        raw2_d  = I_JJOY;
        state_d = UPDATE;
      end
      UPDATE: begin
        state_d  = SEL1_SETTLE;
        settle_d = '0;
        for (int i = 0; i < 18; i++) begin
          if (raw_all[i] == deb_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] + CW'(1) == DEB_LIMIT) begin
            deb_d[i] = raw_all[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        // Release checks the pre-decrement hold so the coin stays low for a full
        // COIN_HOLD_SCANS updates after the one that asserted it.
        for (int n = 0; n < 2; n++) begin
          if (deb_q[16+n] && !deb_d[16+n]) begin
            coin_d[n] = 1'b0;
            hold_d[n] = HOLD_LOAD;
          end else begin
            if (hold_q[n] != 8'd0) hold_d[n] = hold_q[n] - 8'd1;
            if (hold_q[n] == 8'd0 && deb_d[16+n]) coin_d[n] = 1'b1;
          end
        end
      end
      default: state_d = SEL1_SETTLE;
    endcase

    jselect_d = (state_d == SEL2_SETTLE) || (state_d == SAMPLE2);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q   <= SEL1_SETTLE;
      settle_q  <= '0;
      jselect_q <= 1'b0;
      raw1_q    <= '1;
      raw2_q    <= '1;
      rawc_q    <= '1;
      deb_q     <= '1;
      coin_q    <= '1;
      for (int i = 0; i < 18; i++) cnt_q[i] <= '0;
      for (int n = 0; n < 2; n++) hold_q[n] <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      jselect_q <= jselect_d;
      raw1_q    <= raw1_d;
      raw2_q    <= raw2_d;
      rawc_q    <= rawc_d;
      deb_q     <= deb_d;
      coin_q    <= coin_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
    end
  end

  assign O_JSELECT   = jselect_q;
  assign O_JOY1      = deb_q[7:0];
  assign O_JOY2      = deb_q[15:8];
  assign O_COIN      = coin_q;
  assign O_SCAN_DONE = (state_q == UPDATE);

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Directed bench for jamma_input_scanner: reset, mux, glitch, joystick merge,
// coin stretch and mid-scan reset, each against hand-computed values.
module tb_jamma_input_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p1, p2, jjoy;
  logic [5:0] joystick;
  logic [1:0] jcoin;
  logic       jsel, done;
  logic [7:0] joy1, joy2;
  logic [1:0] coin;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The cabinet's external mux: P1 on select 0, P2 on select 1.
  assign jjoy = jsel ? p2 : p1;

  jamma_input_scanner dut (
    .I_CLK       (clk),
    .I_RESET     (rst),
    .I_JJOY      (jjoy),
    .I_JOYSTICK  (joystick),
    .I_JCOIN     (jcoin),
    .O_JSELECT   (jsel),
    .O_JOY1      (joy1),
    .O_JOY2      (joy2),
    .O_COIN      (coin),
    .O_SCAN_DONE (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance to just after the edge that ends the next UPDATE cycle.
  task automatic next_scan();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) break;
    end
    if (n >= 100) check("scan_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  // Cycles from the current (post-reset) cycle until O_SCAN_DONE is seen.
  task automatic count_to_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    p1       = 8'($urandom);
    p2       = 8'($urandom);
    joystick = 6'($urandom);
    jcoin    = 2'($urandom);

    // Reset held for three edges with random inputs
    repeat (3) @(negedge clk);
    check("rst_joy1", 32'(joy1), 32'hFF);
    check("rst_joy2", 32'(joy2), 32'hFF);
    check("rst_coin", 32'(coin), 32'h3);
    check("rst_jsel", 32'(jsel), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    p1 = 8'hFF; p2 = 8'hFF; joystick = 6'h3F; jcoin = 2'b11;
    rst = 1'b0;
    count_to_done(n);
    check("first_done_cycle", 32'(n), 32'd34);

    // Mux: P1=FE, P2=7F appear after the 4th scan, not the 3rd
    p1 = 8'hFE; p2 = 8'h7F;
    repeat (3) next_scan();
    check("mux_joy1_scan3", 32'(joy1), 32'hFF);
    check("mux_joy2_scan3", 32'(joy2), 32'hFF);
    next_scan();
    check("mux_joy1_scan4", 32'(joy1), 32'hFE);
    check("mux_joy2_scan4", 32'(joy2), 32'h7F);

    // Mid-scan reset during SEL2_SETTLE
    n = 0;
    while (jsel && n < 100) begin @(negedge clk); n++; end
    while (!jsel && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("sel2_timeout", 32'(n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    p1 = 8'hFF; p2 = 8'hFF;
    check("midrst_jsel", 32'(jsel), 32'd0);
    check("midrst_joy2", 32'(joy2), 32'hFF);
    check("midrst_joy1", 32'(joy1), 32'hFF);
    count_to_done(n);
    check("midrst_done_cycle", 32'(n), 32'd34);

    // Glitch: P2 bit3 low for 3 scans, high one scan, low 3 scans again
    p2 = 8'hF7;
    repeat (3) next_scan();
    check("glitch_joy2_a", 32'(joy2), 32'hFF);
    p2 = 8'hFF;
    next_scan();
    check("glitch_joy2_b", 32'(joy2), 32'hFF);
    p2 = 8'hF7;
    repeat (3) next_scan();
    check("glitch_joy2_c", 32'(joy2), 32'hFF);
    p2 = 8'hFF;
    next_scan();
    check("glitch_joy2_d", 32'(joy2), 32'hFF);

    // Local joystick merged into P1 only
    joystick = 6'b111110;
    repeat (3) next_scan();
    check("merge_joy1_scan3", 32'(joy1), 32'hFF);
    next_scan();
    check("merge_joy1_scan4", 32'(joy1), 32'hFE);
    check("merge_joy2_scan4", 32'(joy2), 32'hFF);
    joystick = 6'h3F;
    repeat (4) next_scan();
    check("merge_joy1_release", 32'(joy1), 32'hFF);

    // Coin 0 low 4 scans then high: asserted at 4th UPDATE, held 8 more
    jcoin = 2'b10;
    repeat (3) next_scan();
    check("coin_scan3", 32'(coin), 32'h3);
    next_scan();
    check("coin_scan4", 32'(coin), 32'h2);
    jcoin = 2'b11;
    for (int k = 0; k < 8; k++) begin
      next_scan();
      check("coin_hold", 32'(coin), 32'h2);
    end
    next_scan();
    check("coin_release", 32'(coin), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jamma_input_scanner.md
JAMMA_INPUT_SCANNER -- requirements
Module: jamma_input_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, meaning cycles JSELECT is held before each sample (legal range 1..255).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive scans a raw bit must differ from its output before the output flips (legal range 1..15).
REQ-003 SHALL have parameter COIN_HOLD_SCANS, default 8, meaning the minimum number of scans a coin output stays asserted (legal range 1..255).
REQ-004 SHALL have port I_CLK  input  1  system clock (pclk domain); the block SHALL have one clock.
REQ-005 SHALL have port I_RESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port I_JJOY  input  8  JAMMA muxed player bus, active-low; P1 is valid when O_JSELECT=0 and P2 is valid when O_JSELECT=1.
REQ-007 SHALL have port I_JOYSTICK  input  6  local DB9 joystick, active-low, merged into P1.
REQ-008 SHALL have port I_JCOIN  input  2  coin switches, active-low.
REQ-009 SHALL have port O_JSELECT  output  1  JAMMA mux select, driven from a register.
REQ-010 SHALL have port O_JOY1  output  8  debounced P1, active-low, driven from a register.
REQ-011 SHALL have port O_JOY2  output  8  debounced P2, active-low, driven from a register.
REQ-012 SHALL have port O_COIN  output  2  debounced and stretched coins, active-low, driven from a register.
REQ-013 SHALL have port O_SCAN_DONE  output  1  one-cycle pulse at the end of each scan.

Function
REQ-014 SHALL sequence with a 5-state FSM: SEL1_SETTLE -> SAMPLE1 -> SEL2_SETTLE -> SAMPLE2 -> UPDATE -> SEL1_SETTLE, with no other transitions.
REQ-015 SHALL remain in each SETTLE state for exactly SETTLE_CYCLES cycles, using a settle counter that is cleared on entry to the state.
REQ-016 SHALL drive O_JSELECT=1 in SEL2_SETTLE and SAMPLE2, and O_JSELECT=0 in all other states.
REQ-017 SHALL occupy each of SAMPLE1, SAMPLE2 and UPDATE for one cycle, giving a scan period of 2*SETTLE_CYCLES+3 cycles (35 at the defaults).
REQ-018 SHALL in SAMPLE1 capture raw1 = I_JJOY AND {2'b11, I_JOYSTICK}, and raw coin = I_JCOIN.
REQ-019 SHALL in SAMPLE2 capture raw2 = I_JJOY.
REQ-020 SHALL in UPDATE, for each of the 18 bits (16 joy bits and 2 coin bits), apply the following rule: if raw equals the debounced value, clear that bit's counter.
REQ-021 SHALL in UPDATE otherwise increment that bit's counter.
REQ-022 SHALL, when an incremented counter reaches DEBOUNCE_SCANS, load the raw value into the debounced bit and clear the counter.
REQ-023 SHALL never let a debounce counter exceed DEBOUNCE_SCANS, and SHALL size each counter as $clog2(DEBOUNCE_SCANS+1) bits.
REQ-024 SHALL make O_JOY1 and O_JOY2 equal the debounced joy bits, updated on the clock edge that ends UPDATE.
REQ-025 SHALL, on a debounced coin falling to 0, assert O_COIN[n]=0 and load a per-coin hold counter with COIN_HOLD_SCANS.
REQ-026 SHALL decrement the hold counter once per UPDATE while it is non-zero.
REQ-027 SHALL release O_COIN[n] to 1 only when the hold counter is 0 and the debounced coin is 1.
REQ-028 SHALL, if the debounced coin falls again while the hold counter is non-zero, reload the hold counter with COIN_HOLD_SCANS.
REQ-029 SHALL pulse O_SCAN_DONE high for exactly the UPDATE cycle.
REQ-030 SHALL treat a raw bit that returns to the debounced value before its counter reaches DEBOUNCE_SCANS as noise: the counter is cleared and the output does not change.
REQ-031 SHALL NOT sample I_JJOY, I_JOYSTICK or I_JCOIN in any state other than SAMPLE1 and SAMPLE2.

Reset
REQ-032 SHALL, while I_RESET=1 at a clock edge, set: state=SEL1_SETTLE, settle counter=0, O_JSELECT=0, O_JOY1=8'hFF, O_JOY2=8'hFF, O_COIN=2'b11, O_SCAN_DONE=0.
REQ-033 SHALL, under the same condition, clear all raw registers to all ones, all debounce counters to 0 and all hold counters to 0.
REQ-034 SHALL accept reset asserted in any state (including mid-SETTLE), taking effect on the next edge with no partial UPDATE applied.
REQ-035 SHALL, after reset is released, begin the first scan with the first cycle of SEL1_SETTLE and assert the first O_SCAN_DONE 2*SETTLE_CYCLES+2 cycles later (cycle 34 at the defaults).

Verification
REQ-036 SHALL be covered by a reset scenario: hold I_RESET for 3 cycles with random inputs -> O_JOY1=FF, O_JOY2=FF, O_COIN=11, O_JSELECT=0, O_SCAN_DONE=0; the first O_SCAN_DONE occurs 34 cycles after release.
REQ-037 SHALL be covered by a mux scenario: drive I_JJOY=8'hFE while O_JSELECT=0 and 8'h7F while O_JSELECT=1, with I_JOYSTICK=6'h3F -> O_JOY1=FE and O_JOY2=7F after the 4th O_SCAN_DONE, and unchanged (FF) after the 3rd.
REQ-038 SHALL be covered by a glitch scenario: hold P2 bit3 low for 3 scans, then high -> O_JOY2 stays FF throughout.
REQ-039 SHALL be covered by a local joystick merge scenario: I_JJOY=FF, I_JOYSTICK=6'b111110 -> O_JOY1=FE after 4 scans and O_JOY2=FF.
REQ-040 SHALL be covered by a coin stretch scenario: I_JCOIN[0] low for 4 scans, then high -> O_COIN[0]=0 from the 4th UPDATE and held for 8 further UPDATEs, then 1; O_COIN[1]=1 throughout.
REQ-041 SHALL be covered by a mid-scan reset scenario: pulse I_RESET for 1 cycle during SEL2_SETTLE with O_JOY2=7F -> on the next cycle O_JSELECT=0 and O_JOY2=FF, and the following O_SCAN_DONE arrives 34 cycles after reset is released.
